// File: rtl/wa_pkg.sv
// Shared types and default widths for the sif write-address buffer.
package wa_pkg;

   localparam int WA_ADDR_W = 8;
   localparam int WA_DATA_W = 32;

   typedef struct packed {
      logic [WA_ADDR_W-1:0] addr;
      logic [WA_DATA_W-1:0] data;
   } entry_t;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

endpackage

// File: rtl/wa_fifo.sv
// Synchronous FIFO with combinational head read; storage is plain registers.
module wa_fifo #(
   parameter  int W     = 40,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic [LW-1:0] level,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // A push at full is legal only alongside a pop, which frees the head slot.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign full  = (level == LW'(DEPTH));
   assign empty = (level == '0);
   assign dout  = mem[rd_ptr];

   // NOTE: the data array has no reset; only pointers and level define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // see pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/wa_wr_buf.sv
// Write buffer between the sif write port and memory: FIFO, drain FSM, overflow flag.
module wa_wr_buf
   import wa_pkg::*;
#(
   parameter  int ADDR_W = WA_ADDR_W,
   parameter  int DATA_W = WA_DATA_W,
   parameter  int DEPTH  = 4,
   localparam int LW     = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wa_wr_s,
   input  logic [ADDR_W-1:0] wa_addr,
   input  logic [DATA_W-1:0] wa_data_wr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   input  logic              mem_ack,
   output logic [LW-1:0]     level,
   output logic              empty,
   output logic              full,
   output logic              ovf,
   input  logic              ovf_clr
);

   state_t            state;
   state_t            state_next;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   assign pop  = mem_req & mem_ack;
   assign push = wa_wr_s & (~full | pop);

   wa_fifo #(
      .W     (ADDR_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ({wa_addr, wa_data_wr}),
      .dout  ({head_addr, head_data}),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: defaulting the target first keeps every path assigned, so no latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (!empty) state_next = REQ;
         REQ:  if (pop && (level == LW'(1)) && !push) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Head contents are masked while idle so stale storage never shows after reset.
   always_comb begin
      mem_req  = (state == REQ);
      mem_addr = mem_req ? head_addr : '0;
      mem_data = mem_req ? head_data : '0;
   end

   // Setting wins over clearing when both happen on one edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  ovf <= 1'b0;
      else if (wa_wr_s && !push) ovf <= 1'b1;
      else if (ovf_clr)          ovf <= 1'b0;
   end

endmodule

// File: tb/tb_wa_wr_buf.sv
// Directed bench for wa_wr_buf: latency, fill/overflow, push-at-full, ovf clear, mid-transaction reset.
module tb_wa_wr_buf;
   import wa_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        wa_wr_s;
   logic [7:0]  wa_addr;
   logic [31:0] wa_data_wr;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic [31:0] mem_data;
   logic        mem_ack;
   logic [2:0]  level;
   logic        empty;
   logic        full;
   logic        ovf;
   logic        ovf_clr;

   int total = 0;
   int bad   = 0;

   entry_t exp_q [4];

   always #5 clk = ~clk;

   wa_wr_buf #(.ADDR_W(8), .DATA_W(32), .DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .wa_wr_s    (wa_wr_s),
      .wa_addr    (wa_addr),
      .wa_data_wr (wa_data_wr),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .mem_ack    (mem_ack),
      .level      (level),
      .empty      (empty),
      .full       (full),
      .ovf        (ovf),
      .ovf_clr    (ovf_clr)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_wr(input logic [7:0] a, input logic [31:0] d);
      wa_wr_s    = 1'b1;
      wa_addr    = a;
      wa_data_wr = d;
   endtask

   initial begin
      rst = 1'b1; wa_wr_s = 1'b0; wa_addr = '0; wa_data_wr = '0;
      mem_ack = 1'b0; ovf_clr = 1'b0;

      // Reset values before any clock edge
      #3;
      check("rst_req",   mem_req,  0);
      check("rst_addr",  mem_addr, 0);
      check("rst_data",  mem_data, 0);
      check("rst_level", level,    0);
      check("rst_empty", empty,    1);
      check("rst_full",  full,     0);
      check("rst_ovf",   ovf,      0);
      step(); step();
      rst = 1'b0;

      // Single write, ack tied high; first edge after reset release
      mem_ack = 1'b1;
      drive_wr(8'h10, 32'hDEADBEEF);
      step();
      wa_wr_s = 1'b0;
      check("t1_req_k",   mem_req, 0);
      check("t1_level_k", level,   1);
      step();
      check("t1_req_k1",  mem_req,  1);
      check("t1_addr",    mem_addr, 8'h10);
      check("t1_data",    mem_data, 32'hDEADBEEF);
      step();
      check("t1_req_k2",  mem_req, 0);
      check("t1_level_0", level,   0);
      check("t1_empty",   empty,   1);
      // Ack while idle is ignored
      step();
      check("t1_idle_ack_req",   mem_req, 0);
      check("t1_idle_ack_level", level,   0);
      mem_ack = 1'b0;

      // Fill to full with ack low, then overflow
      for (int i = 0; i < 4; i++) begin
         exp_q[i].addr = 8'hA0 + 8'(i);
         exp_q[i].data = 32'hC0DE_0000 + 32'(i * 17);
      end
      for (int i = 0; i < 4; i++) begin
         drive_wr(exp_q[i].addr, exp_q[i].data);
         step();
      end
      check("t2_full",  full,     1);
      check("t2_level", level,    4);
      check("t2_req",   mem_req,  1);
      check("t2_head",  mem_addr, 8'hA0);
      drive_wr(8'hEE, 32'h1111_2222);
      step();
      wa_wr_s = 1'b0;
      check("t2_ovf",       ovf,      1);
      check("t2_ovf_level", level,    4);
      check("t2_hold_addr", mem_addr, 8'hA0);
      check("t2_hold_data", mem_data, 32'hC0DE_0000);
      mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_drain_req%0d", i),  mem_req,  1);
         check($sformatf("t2_drain_addr%0d", i), mem_addr, exp_q[i].addr);
         check($sformatf("t2_drain_data%0d", i), mem_data, exp_q[i].data);
         step();
      end
      mem_ack = 1'b0;
      check("t2_end_req",   mem_req, 0);
      check("t2_end_empty", empty,   1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("t2_ovf_clr", ovf, 0);

      // Push at full alongside a pop
      for (int i = 0; i < 4; i++) begin
         drive_wr(8'h20 + 8'(i), 32'h100 + 32'(i));
         step();
      end
      check("t3_full", full, 1);
      drive_wr(8'h55, 32'h55);
      mem_ack = 1'b1;
      step();
      wa_wr_s = 1'b0;
      check("t3_level", level,    4);
      check("t3_ovf",   ovf,      0);
      check("t3_head",  mem_addr, 8'h21);
      check("t3_d1",    mem_data, 32'h101);
      step();
      check("t3_a2", mem_addr, 8'h22);
      step();
      check("t3_a3", mem_addr, 8'h23);
      step();
      check("t3_a4",   mem_addr, 8'h55);
      check("t3_d4",   mem_data, 32'h55);
      check("t3_lvl1", level,    1);
      step();
      mem_ack = 1'b0;
      check("t3_end_req",   mem_req, 0);
      check("t3_end_level", level,   0);

      // Overflow set beats a coincident clear
      for (int i = 0; i < 5; i++) begin
         drive_wr(8'h30 + 8'(i), 32'h200 + 32'(i));
         step();
      end
      check("t4_ovf_set", ovf, 1);
      ovf_clr = 1'b1;
      step();
      check("t4_set_wins", ovf, 1);
      wa_wr_s = 1'b0;
      step();
      ovf_clr = 1'b0;
      check("t4_clr",   ovf,      0);
      check("t4_head",  mem_addr, 8'h30);

      // Reset in REQ with level 3
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check("t5_level3", level,    3);
      check("t5_req",    mem_req,  1);
      #2;
      rst = 1'b1;
      #1;
      check("t5_async_req",   mem_req,  0);
      check("t5_async_level", level,    0);
      check("t5_async_empty", empty,    1);
      check("t5_async_addr",  mem_addr, 0);
      step();
      rst = 1'b0;
      drive_wr(8'h77, 32'h1234);
      step();
      wa_wr_s = 1'b0;
      check("t5_wr_req",   mem_req, 0);
      check("t5_wr_level", level,   1);
      step();
      check("t5_req_on", mem_req,  1);
      check("t5_addr",   mem_addr, 8'h77);
      check("t5_data",   mem_data, 32'h1234);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check("t5_done", empty, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
